alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 58 +++++
 rtl/alu_issue_ctrl_alu_op_decode.sv | 64 ++++++
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the ALU issue controller and the ALU itself:
//   - FSM state encoding of the issue controller
//   - opcode and R-type funct constants
//   - 4-bit ALU control codes ([2:0] operation, [3] shift amount from shamt)
//   - bit positions inside the {carry, neg, zero} flag vector
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_WB      = 2'd3
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_ANDI  = 6'd2;
  localparam logic [5:0] OP_XORI  = 6'd3;
  localparam logic [5:0] OP_BZ    = 6'd4;
  localparam logic [5:0] OP_BNZ   = 6'd5;
  localparam logic [5:0] OP_BLTZ  = 6'd6;

  // R-type funct codes
  localparam logic [4:0] FN_ADD  = 5'd0;
  localparam logic [4:0] FN_COMP = 5'd1;
  localparam logic [4:0] FN_AND  = 5'd2;
  localparam logic [4:0] FN_XOR  = 5'd3;
  localparam logic [4:0] FN_SLL  = 5'd4;
  localparam logic [4:0] FN_SRL  = 5'd5;
  localparam logic [4:0] FN_SRA  = 5'd6;
  localparam logic [4:0] FN_SLLV = 5'd7;
  localparam logic [4:0] FN_SRLV = 5'd8;
  localparam logic [4:0] FN_SRAV = 5'd9;
  localparam logic [4:0] FN_DIFF = 5'd10;

  // ALU control codes: bit 3 = shift amount taken from the shamt field
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_COMP = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLLV = 4'b0100;
  localparam logic [3:0] ALU_SRLV = 4'b0101;
  localparam logic [3:0] ALU_SRAV = 4'b0110;
  localparam logic [3:0] ALU_DIFF = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;

  // Bit positions in the registered flag vector {carry, neg, zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;

endpackage

// File: rtl/alu_issue_ctrl_alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational instruction decoder.
// Ports:
//   opcode_i      [5:0] instruction class
//   funct_i       [4:0] R-type sub-operation
//   alu_ctrl_o    [3:0] ALU control code
//   alu_src_imm_o       immediate selected as ALU operand 2
//   is_branch_o         instruction is a conditional branch
//   legal_o             opcode/funct combination is defined
// Undefined encodings report legal_o=0 with an inert ADD / register operand.
// -----------------------------------------------------------------------------
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [4:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       alu_src_imm_o,
  output logic       is_branch_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctrl_o    = ALU_ADD;
    alu_src_imm_o = 1'b0;
    is_branch_o   = 1'b0;
    legal_o       = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_COMP: alu_ctrl_o = ALU_COMP;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_XOR:  alu_ctrl_o = ALU_XOR;
          FN_SLL:  alu_ctrl_o = ALU_SLL;
          FN_SRL:  alu_ctrl_o = ALU_SRL;
          FN_SRA:  alu_ctrl_o = ALU_SRA;
          FN_SLLV: alu_ctrl_o = ALU_SLLV;
          FN_SRLV: alu_ctrl_o = ALU_SRLV;
          FN_SRAV: alu_ctrl_o = ALU_SRAV;
          FN_DIFF: alu_ctrl_o = ALU_DIFF;
          default: legal_o    = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu_ctrl_o    = ALU_ADD;
        alu_src_imm_o = 1'b1;
      end
      OP_ANDI: begin
        alu_ctrl_o    = ALU_AND;
        alu_src_imm_o = 1'b1;
      end
      OP_XORI: begin
        alu_ctrl_o    = ALU_XOR;
        alu_src_imm_o = 1'b1;
      end
      // Branches compare via the ALU adder; the condition is resolved later
      OP_BZ, OP_BNZ, OP_BLTZ: is_branch_o = 1'b1;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Four-state issue controller (IDLE -> DECODE -> EXECUTE -> WB) that drives
// ALU control, captures ALU flags and produces write-back / branch pulses.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready  instruction handshake (ready only in IDLE)
//   opcode, funct              instruction fields, sampled on accept
//   kill                       flush; abandons an instruction in DECODE/EXECUTE
//   alu_zero/neg/carry         ALU flag inputs, sampled at end of EXECUTE
//   alu_ctrl, alu_src_imm      registered ALU controls, held DECODE..WB
//   rf_we, branch_taken        single-cycle pulses in WB
//   illegal                    single-cycle pulse in DECODE
//   flags                      registered {carry, neg, zero}
// -----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] opcode,
  input  logic [4:0] funct,
  input  logic       kill,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       alu_carry,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_imm,
  output logic       rf_we,
  output logic       branch_taken,
  output logic       illegal,
  output logic [2:0] flags
);

  state_e     state_q, state_d;
  logic [3:0] alu_ctrl_q, alu_ctrl_d;
  logic       src_imm_q, src_imm_d;
  logic       is_branch_q, is_branch_d;
  logic       legal_q, legal_d;
  logic [5:0] opcode_q, opcode_d;
  logic [2:0] flags_q, flags_d;

  logic [3:0] dec_alu_ctrl;
  logic       dec_src_imm;
  logic       dec_is_branch;
  logic       dec_legal;
  logic       branch_cond;

  // Decode the raw input fields so the control word is registered on accept
  // and is already valid throughout DECODE.
  alu_op_decode u_alu_op_decode (
    .opcode_i      (opcode),
    .funct_i       (funct),
    .alu_ctrl_o    (dec_alu_ctrl),
    .alu_src_imm_o (dec_src_imm),
    .is_branch_o   (dec_is_branch),
    .legal_o       (dec_legal)
  );

  // Branch condition evaluated on the registered flags during WB
  always_comb begin
    case (opcode_q)
      OP_BZ:   branch_cond = flags_q[FLAG_ZERO];
      OP_BNZ:  branch_cond = ~flags_q[FLAG_ZERO];
      OP_BLTZ: branch_cond = flags_q[FLAG_NEG];
      default: branch_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    alu_ctrl_d   = alu_ctrl_q;
    src_imm_d    = src_imm_q;
    is_branch_d  = is_branch_q;
    legal_d      = legal_q;
    opcode_d     = opcode_q;
    flags_d      = flags_q;
    instr_ready  = 1'b0;
    rf_we        = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_d     = ST_DECODE;
          alu_ctrl_d  = dec_alu_ctrl;
          src_imm_d   = dec_src_imm;
          is_branch_d = dec_is_branch;
          legal_d     = dec_legal;
          opcode_d    = opcode;
        end
      end
      ST_DECODE: begin
        // kill outranks the illegal report
        illegal = ~legal_q & ~kill;
        if (kill || !legal_q) state_d = ST_IDLE;
        else                  state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WB;
          flags_d = {alu_carry, alu_neg, alu_zero};
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        if (is_branch_q) branch_taken = branch_cond;
        else             rf_we        = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Leaving for IDLE always drops the control word back to ADD/register
    if (state_d == ST_IDLE) begin
      alu_ctrl_d  = ALU_ADD;
      src_imm_d   = 1'b0;
      is_branch_d = 1'b0;
      legal_d     = 1'b0;
      opcode_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_ctrl_q  <= ALU_ADD;
      src_imm_q   <= 1'b0;
      is_branch_q <= 1'b0;
      legal_q     <= 1'b0;
      opcode_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      alu_ctrl_q  <= alu_ctrl_d;
      src_imm_q   <= src_imm_d;
      is_branch_q <= is_branch_d;
      legal_q     <= legal_d;
      opcode_q    <= opcode_d;
      flags_q     <= flags_d;
    end
  end

  assign alu_ctrl    = alu_ctrl_q;
  assign alu_src_imm = src_imm_q;
  assign flags       = flags_q;

endmodule
